// File: rtl/vip_cfg_slave.sv
// vip_cfg_slave: Avalon-MM write-only responder for the VIP configuration bus
//
// Decodes address {unit[1:0], reg[6:0]} into scaler (0), mixer (1) and
// video-mode (2) register units. Writes land in shadow registers; a Go write
// arms a per-unit commit that copies shadow to active on the next frame_start.
// Scaler coefficient taps are staged, then streamed as a 4-beat burst.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   address, write, writedata  Avalon-MM write request
//   waitrequest                stall; write accepted when write && !waitrequest
//   frame_start                output frame boundary pulse (commit point)
//   vm_*                       active video-mode timing
//   mx_*                       active mixer background size / layer position
//   sc_ow, sc_oh               active scaler output size
//   upd                        per-unit commit pulse {vm, mx, sc}
//   coef_*                     coefficient RAM write port
//
// Optional build macro VIP_CFG_READBACK_EN adds read / readdata /
// readdatavalid for shadow register readback.
module vip_cfg_slave #(
    parameter int RES_W = 12,
    parameter int NTAPS = 4,
    parameter int PH_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [8:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic             waitrequest,
    input  logic             frame_start,
    output logic [RES_W-1:0] vm_w,
    output logic [RES_W-1:0] vm_h,
    output logic [RES_W-1:0] vm_hfp,
    output logic [RES_W-1:0] vm_hs,
    output logic [RES_W-1:0] vm_hb,
    output logic [RES_W-1:0] vm_vfp,
    output logic [RES_W-1:0] vm_vs,
    output logic [RES_W-1:0] vm_vb,
    output logic             vm_interlaced,
    output logic [RES_W-1:0] mx_bw,
    output logic [RES_W-1:0] mx_bh,
    output logic [RES_W-1:0] mx_px,
    output logic [RES_W-1:0] mx_py,
    output logic             mx_en,
    output logic [RES_W-1:0] sc_ow,
    output logic [RES_W-1:0] sc_oh,
    output logic [2:0]       upd,
    output logic             coef_wr,
    output logic             coef_dir,
    output logic [PH_W-1:0]  coef_phase,
    output logic [1:0]       coef_tap,
    output logic [8:0]       coef_data
`ifdef VIP_CFG_READBACK_EN
    ,
    input  logic             read,
    output logic [31:0]      readdata,
    output logic             readdatavalid
`endif
);
    typedef enum logic [2:0] {IDLE, B0, B1, B2, B3} state_t;

    logic [1:0]       unit;
    logic [6:0]       rg;
    logic [RES_W-1:0] wd;
    logic             acc, coef_go, wait_q, wait_d;
    logic [2:0]       go, commit, pend_q, pend_d, upd_q;
    logic             bank_q, valid_q, il_s_q, il_a_q, en_s_q, en_a_q;
    logic [RES_W-1:0] vm_s_q [8];
    logic [RES_W-1:0] vm_a_q [8];
    logic [RES_W-1:0] mx_s_q [4];
    logic [RES_W-1:0] mx_a_q [4];
    logic [RES_W-1:0] sc_s_q [2];
    logic [RES_W-1:0] sc_a_q [2];
    logic [8:0]       stage_q [NTAPS];
    logic             vm_hit, mx_hit, sc_hit;
    logic [2:0]       vm_idx;
    logic [1:0]       mx_idx;
    logic             sc_idx;
    state_t           state_q;
    logic             coef_wr_q, coef_dir_q;
    logic [PH_W-1:0]  coef_phase_q;
    logic [1:0]       coef_tap_q;
    logic [8:0]       coef_data_q;
    logic             unused;

    assign {unit, rg} = address;
    assign wd         = writedata[RES_W-1:0];
    assign unused     = &{1'b0, writedata[31:RES_W]};
    assign acc        = write && !wait_q;
    assign coef_go    = acc && unit == 2'd0 && (rg == 7'd12 || rg == 7'd13);

    // Go sets pend only for bit 0; a Go in the frame_start cycle survives the
    // commit clear so it is picked up at the following frame_start.
    assign go[0]  = acc && unit == 2'd0 && rg == 7'd0 && writedata[0];
    assign go[1]  = acc && unit == 2'd1 && rg == 7'd0 && writedata[0];
    assign go[2]  = acc && unit == 2'd2 && rg == 7'd0 && writedata[0];
    assign commit = frame_start ? {pend_q[2] & valid_q, pend_q[1:0]} : 3'b000;
    assign pend_d = go | (pend_q & ~commit);
    // Stall the cycle after any accepted write and for the rest of a burst.
    assign wait_d = acc || state_q inside {B0, B1, B2};

    always_comb begin
        vm_hit = 1'b1;
        vm_idx = 3'd0;
        case (rg)
            7'd6:    vm_idx = 3'd0;
            7'd7:    vm_idx = 3'd1;
            7'd9:    vm_idx = 3'd2;
            7'd10:   vm_idx = 3'd3;
            7'd11:   vm_idx = 3'd4;
            7'd12:   vm_idx = 3'd5;
            7'd13:   vm_idx = 3'd6;
            7'd14:   vm_idx = 3'd7;
            default: vm_hit = 1'b0;
        endcase
    end

    always_comb begin
        mx_hit = rg == 7'd3 || rg == 7'd4 || rg == 7'd8 || rg == 7'd9;
        mx_idx = {rg[3], rg == 7'd4 || rg == 7'd9};
        sc_hit = rg == 7'd3 || rg == 7'd4;
        sc_idx = rg == 7'd4;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_q  <= 1'b0;
            valid_q <= 1'b0;
            il_s_q  <= 1'b0;
            en_s_q  <= 1'b0;
            vm_s_q  <= '{default: '0};
            mx_s_q  <= '{default: '0};
            sc_s_q  <= '{default: '0};
            stage_q <= '{default: '0};
        end else if (acc) begin
            case (unit)
                2'd2: begin
                    if (rg == 7'd4) bank_q <= writedata[0];
                    if (rg == 7'd30) valid_q <= writedata[0];
                    if (!bank_q && rg == 7'd5) il_s_q <= writedata[0];
                    if (!bank_q && vm_hit) vm_s_q[vm_idx] <= wd;
                end
                2'd1: begin
                    if (mx_hit) mx_s_q[mx_idx] <= wd;
                    if (rg == 7'd10) en_s_q <= writedata[0];
                end
                2'd0: begin
                    if (sc_hit) sc_s_q[sc_idx] <= wd;
                    for (int t = 0; t < NTAPS; t++)
                        if (rg == 7'(14 + t)) stage_q[t] <= writedata[8:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vm_a_q <= '{default: '0};
            mx_a_q <= '{default: '0};
            sc_a_q <= '{default: '0};
            il_a_q <= 1'b0;
            en_a_q <= 1'b0;
            pend_q <= 3'b000;
            upd_q  <= 3'b000;
            wait_q <= 1'b1;
        end else begin
            if (commit[2]) begin
                vm_a_q <= vm_s_q;
                il_a_q <= il_s_q;
            end
            if (commit[1]) begin
                mx_a_q <= mx_s_q;
                en_a_q <= en_s_q;
            end
            if (commit[0]) sc_a_q <= sc_s_q;
            pend_q <= pend_d;
            upd_q  <= commit;
            wait_q <= wait_d;
        end
    end

    // Coefficient burst: beat k is presented in state Bk with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            coef_wr_q    <= 1'b0;
            coef_dir_q   <= 1'b0;
            coef_phase_q <= '0;
            coef_tap_q   <= 2'd0;
            coef_data_q  <= 9'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    coef_wr_q <= coef_go;
                    if (coef_go) begin
                        state_q      <= B0;
                        coef_dir_q   <= rg[0];
                        coef_phase_q <= writedata[PH_W-1:0];
                        coef_tap_q   <= 2'd0;
                        coef_data_q  <= stage_q[0];
                    end
                end
                B3: begin
                    state_q   <= IDLE;
                    coef_wr_q <= 1'b0;
                end
                default: begin
                    state_q     <= state_t'(state_q + 3'd1);
                    coef_tap_q  <= coef_tap_q + 2'd1;
                    coef_data_q <= stage_q[coef_tap_q + 2'd1];
                end
            endcase
        end
    end

`ifdef VIP_CFG_READBACK_EN
    logic        racc, rdv_q;
    logic [31:0] rd_d, rd_q;

    // A write in the same cycle takes priority; the read is held off.
    assign racc = read && !wait_q && !write;

    always_comb begin
        rd_d = '0;
        case (unit)
            2'd2: begin
                if (rg == 7'd0) rd_d = 32'(pend_q[2]);
                if (rg == 7'd4) rd_d = 32'(bank_q);
                if (rg == 7'd5) rd_d = 32'(il_s_q);
                if (vm_hit) rd_d = 32'(vm_s_q[vm_idx]);
                if (rg == 7'd30) rd_d = 32'(valid_q);
            end
            2'd1: begin
                if (rg == 7'd0) rd_d = 32'(pend_q[1]);
                if (mx_hit) rd_d = 32'(mx_s_q[mx_idx]);
                if (rg == 7'd10) rd_d = 32'(en_s_q);
            end
            2'd0: begin
                if (rg == 7'd0) rd_d = 32'(pend_q[0]);
                if (sc_hit) rd_d = 32'(sc_s_q[sc_idx]);
                for (int t = 0; t < NTAPS; t++)
                    if (rg == 7'(14 + t)) rd_d = 32'(stage_q[t]);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q  <= '0;
            rdv_q <= 1'b0;
        end else begin
            rdv_q <= racc;
            if (racc) rd_q <= rd_d;
        end
    end

    assign readdata      = rd_q;
    assign readdatavalid = rdv_q;
`else
`endif

    assign waitrequest   = wait_q;
    assign vm_w          = vm_a_q[0];
    assign vm_h          = vm_a_q[1];
    assign vm_hfp        = vm_a_q[2];
    assign vm_hs         = vm_a_q[3];
    assign vm_hb         = vm_a_q[4];
    assign vm_vfp        = vm_a_q[5];
    assign vm_vs         = vm_a_q[6];
    assign vm_vb         = vm_a_q[7];
    assign vm_interlaced = il_a_q;
    assign mx_bw         = mx_a_q[0];
    assign mx_bh         = mx_a_q[1];
    assign mx_px         = mx_a_q[2];
    assign mx_py         = mx_a_q[3];
    assign mx_en         = en_a_q;
    assign sc_ow         = sc_a_q[0];
    assign sc_oh         = sc_a_q[1];
    assign upd           = upd_q;
    assign coef_wr       = coef_wr_q;
    assign coef_dir      = coef_dir_q;
    assign coef_phase    = coef_phase_q;
    assign coef_tap      = coef_tap_q;
    assign coef_data     = coef_data_q;
endmodule

// File: doc/vip_cfg_slave.md
Name: vip_cfg_slave

Overview:
- Avalon-MM write-only slave; the responder end of the VIP configuration bus.
- Decodes 9-bit addresses {unit[1:0], reg[6:0]} into three register units: scaler (0), mixer (1) and video-mode (2).
- Register writes land in shadow registers. A Go write arms a per-unit commit, and the shadow values are copied to the active outputs on the next frame_start.
- Scaler coefficient writes are staged per tap and then streamed to the scaler's coefficient RAM as a 4-beat burst.

Parameters:
- RES_W, 12: width of every geometry register/output.
- NTAPS, 4: coefficient taps per phase (staging regs 14..14+NTAPS-1).
- PH_W, 4: phase index width.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- address  in  9  {unit, reg}.
- write  in  1  write strobe.
- writedata  in  32  write data; only [RES_W-1:0] used except where noted.
- waitrequest  out  1  stall; a write is accepted when write && !waitrequest.
- frame_start  in  1  one-cycle pulse at output frame boundary.
- vm_w, vm_h, vm_hfp, vm_hs, vm_hb, vm_vfp, vm_vs, vm_vb  out  RES_W each  active video-mode timing.
- vm_interlaced  out  1  active progressive(0)/interlaced(1).
- mx_bw, mx_bh, mx_px, mx_py  out  RES_W each  active mixer background size and layer position.
- mx_en  out  1  active mixer layer-0 enable.
- sc_ow, sc_oh  out  RES_W each  active scaler output size.
- upd  out  3  one-cycle pulse per unit {vm, mx, sc} on commit.
- coef_wr  out  1  coefficient RAM write strobe.
- coef_dir  out  1  0 = horizontal, 1 = vertical.
- coef_phase  out  PH_W  coefficient phase.
- coef_tap  out  2  coefficient tap index.
- coef_data  out  9  coefficient value.

Behaviour:
- Reset: all shadow, active and staging regs are 0, upd=0, coef_wr=0, pending flags 0, vm_valid=0, vm_bank=0, waitrequest=1.
  - waitrequest falls on the first cycle after reset deasserts.
  - Reset mid-burst aborts the burst; no further coef_wr.
- Write acceptance: one cycle after any accepted write, waitrequest=1 for exactly one cycle. Maximum throughput is therefore one write per 2 cycles.
- Unit 2 (video mode) register map:
  - reg 4: bank; stores writedata[0].
  - reg 5: interlaced.
  - reg 6: w; reg 7: h; reg 9: hfp; reg 10: hs; reg 11: hb; reg 12: vfp; reg 13: vs; reg 14: vb.
  - reg 30: valid (writedata[0]).
  - reg 0: Go, when writedata[0]=1.
  - Writes to regs 5-14 are ignored while bank!=0.
- Unit 1 (mixer) register map: reg 3 bw, reg 4 bh, reg 8 px, reg 9 py, reg 10 en (writedata[0]), reg 0 Go.
- Unit 0 (scaler) register map:
  - reg 3 ow, reg 4 oh, reg 0 Go.
  - regs 14..17: coefficient tap staging, writedata[8:0].
  - regs 12/13: coefficient commit.
- Unmapped regs and unit 3: accepted and ignored, with no side effects.
- Go: sets pend[unit]. Go with writedata[0]=0 is ignored.
- Commit on frame_start:
  - Each pending unit copies shadow to active in the same cycle, clears its pend bit, and pulses upd[unit] on the next cycle.
  - The video-mode unit commits only if valid=1. If valid=0 its pend bit stays set.
- Simultaneous events:
  - Go accepted in the same cycle as frame_start: the shadow is not copied; pend is set and the commit occurs at the following frame_start.
  - Shadow writes in a commit cycle are not included in that commit.
- Active outputs change only at commit, never directly on a register write.
- Coefficient burst: an accepted write to reg 12 (dir=0) or reg 13 (dir=1) latches phase=writedata[PH_W-1:0] and starts BURST.
  - States: IDLE -> B0..B3 -> IDLE.
  - Beat k drives coef_wr=1, coef_tap=k, coef_data=stage[k].
  - Beats fall on 4 consecutive cycles, starting the cycle after acceptance.
  - waitrequest=1 throughout the burst, and for the normal 1-cycle gap after it if shorter.
  - frame_start commits still occur during the burst.
  - Staging registers persist after the burst and are not cleared.
- No readback. Writes to reg 0 with other bits set are treated as Go only for bit 0.

Optional Feature:
- Macro VIP_CFG_READBACK_EN.
- When defined, adds ports:
  - read, in, 1.
  - readdata, out, 32.
  - readdatavalid, out, 1.
- Read behaviour:
  - An accepted read returns the shadow register, zero-extended, with readdatavalid one cycle later.
  - reg 0 returns {pend[unit]}.
  - reg 30 returns valid.
  - Unmapped regs return 0.
  - Read and write accepted together: the write wins and the read is stalled.
- When undefined, there are no extra ports and reads do not exist.

Test Plan:
- Write unit1 bw=320, bh=224, px=16, py=8, en=1, then Go, then pulse frame_start -> mx_* stay 0 until frame_start; next cycle mx_bw=320, mx_bh=224, mx_px=16, mx_py=8, mx_en=1, upd=3'b010 for 1 cycle.
- Video mode with valid=0: Go then frame_start -> vm_* unchanged, pend[2] remains set. Write valid=1 then frame_start -> vm_w etc. committed, upd[2] pulses.
- Write stage taps 14..17 = 9'h010, 9'h0F0, 9'h1F0, 9'h000, then reg 13 data 5 -> 4 consecutive coef_wr beats with dir=1, phase=5, tap 0..3 and matching data; waitrequest high during the burst.
- Go accepted in the frame_start cycle -> no commit that frame; commit at next frame_start.
- Reset asserted during beat B1 -> coef_wr=0 the next cycle; all active outputs 0; waitrequest=1 during reset, 0 one cycle after release.
- Bank=1 then write reg 6 = 640, bank=0, Go, valid=1, frame_start -> vm_w=0 (the bank-1 write was ignored).
